// File: rtl/inst_fetch.sv
// Instruction fetch unit: single-outstanding request engine feeding an instruction/PC FIFO.
// Optional feature: define INST_FETCH_MISALIGN_CHK_EN for a sticky misaligned-redirect fault.
module inst_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h8000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        fetch_fault
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [31:0]     r_fetch_pc;
   logic [31:0]     r_req_pc;
   logic            r_fault;
   logic [31:0]     r_fifo_inst [FIFO_DEPTH];
   logic [31:0]     r_fifo_pc   [FIFO_DEPTH];
   logic [AW-1:0]   r_rd_ptr;
   logic [AW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;
   logic [31:0]     w_redirect_tgt;
   logic            w_fault_set;
   logic            w_empty;
   logic            w_req_fire;
   logic            w_push;
   logic            w_pop;

`ifdef INST_FETCH_MISALIGN_CHK_EN
   assign w_redirect_tgt = redirect_pc;
   assign w_fault_set    = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign fetch_fault    = r_fault;
`else
   assign w_redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
   assign w_fault_set    = 1'b0;
   assign fetch_fault    = 1'b0;
`endif

   // A free FIFO slot is required at issue, so the eventual response always fits.
   assign w_empty        = (r_count == CW'(0));
   assign imem_req_valid = !reset && (r_state == S_IDLE) && !halt && !r_fault &&
                           !redirect_valid && (r_count < CW'(FIFO_DEPTH));
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;
   assign w_push         = (r_state == S_WAIT) && imem_resp_valid && !redirect_valid;
   assign w_pop          = !w_empty && out_ready && !redirect_valid;

   assign out_valid = !w_empty;
   assign out_inst  = w_empty ? 32'h0000_0000 : r_fifo_inst[r_rd_ptr];
   assign out_pc    = w_empty ? 32'h0000_0000 : r_fifo_pc[r_rd_ptr];

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req_fire) w_state_nxt = S_WAIT;
            else            w_state_nxt = S_IDLE;
         end
         S_WAIT: begin
            if (imem_resp_valid)     w_state_nxt = S_IDLE;
            else if (redirect_valid) w_state_nxt = S_DRAIN;
            else                     w_state_nxt = S_WAIT;
         end
         S_DRAIN: begin
            if (imem_resp_valid) w_state_nxt = S_IDLE;
            else                 w_state_nxt = S_DRAIN;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Control state, fetch PC, request PC and sticky fault.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= 32'h0000_0000;
         r_fault    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (redirect_valid)  r_fetch_pc <= w_redirect_tgt;
         else if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
         else                 r_fetch_pc <= r_fetch_pc;
         if (w_req_fire) r_req_pc <= r_fetch_pc;
         else            r_req_pc <= r_req_pc;
         if (w_fault_set) r_fault <= 1'b1;
         else             r_fault <= r_fault;
      end
   end

   // FIFO pointers and occupancy; a redirect flushes everything.
   always_ff @(posedge clk) begin
      if (reset || redirect_valid) begin
         r_rd_ptr <= AW'(0);
         r_wr_ptr <= AW'(0);
         r_count  <= CW'(0);
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         else        r_wr_ptr <= r_wr_ptr;
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         else       r_rd_ptr <= r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; the head is masked while empty so no reset is needed here.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_inst[r_wr_ptr] <= imem_resp_data;
         r_fifo_pc[r_wr_ptr]   <= r_req_pc;
      end
   end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the instruction-buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have ports imem_req_valid output 1, imem_req_ready input 1, imem_req_addr output 32, meaning the instruction-memory request channel.
REQ-006 SHALL have ports imem_resp_valid input 1 and imem_resp_data input 32, meaning the in-order instruction-memory response, always accepted.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1, out_inst output 32, out_pc output 32, meaning the instruction/PC pair handed to the decoder.
REQ-008 SHALL have ports redirect_valid input 1 and redirect_pc input 32, meaning a branch/jump redirect from execute.
REQ-009 SHALL have port halt  input  1  meaning stop issuing new fetches (level-sensitive).
REQ-010 SHALL have port fetch_fault  output  1  meaning a sticky misaligned-redirect fault.

Function
REQ-011 SHALL use three states:
- IDLE: may issue a request.
- WAIT: one request outstanding.
- DRAIN: one stale response is pending and must be discarded.
REQ-012 SHALL drive imem_req_valid = IDLE && !halt && !fetch_fault && !redirect_valid && fifo_count<FIFO_DEPTH, with imem_req_addr = fetch_pc.
REQ-013 SHALL, on a request handshake (valid && ready), move IDLE->WAIT and set fetch_pc <= fetch_pc+4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-014 SHALL hold imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0.
REQ-015 SHALL have at most one request outstanding.
REQ-016 SHALL, in WAIT when imem_resp_valid=1, push {pc of the request, imem_resp_data} into the FIFO and return to IDLE; the earliest next request is the following cycle.
REQ-017 SHALL present the FIFO head on out_inst/out_pc with out_valid = !empty, and pop when out_valid && out_ready.
REQ-018 SHALL, on a simultaneous push and pop, leave the count unchanged and preserve entry order.
REQ-019 SHALL never overflow, because the slot is reserved at request issue.
REQ-020 SHALL give redirect_valid highest priority:
- the FIFO is flushed, so out_valid=0 the next cycle;
- fetch_pc <= redirect_pc;
- any pop in the same cycle has no further effect.
REQ-021 SHALL, on a redirect in WAIT, go to DRAIN if imem_resp_valid=0 in that cycle.
REQ-022 SHALL, on a redirect in WAIT with imem_resp_valid=1 in that cycle, discard the response and go to IDLE.
REQ-023 SHALL, in DRAIN, discard the next response and go to IDLE; a redirect in DRAIN updates fetch_pc and stays in DRAIN.
REQ-024 SHALL, while halt=1, issue no new requests, yet still accept an outstanding response and still drain the FIFO.

Reset
REQ-025 SHALL, with reset=1 at a clock edge, set:
- fetch_pc=RESET_PC, state=IDLE;
- FIFO empty, out_valid=0, out_inst=0, out_pc=0;
- fetch_fault=0, imem_req_valid=0 for that cycle.
REQ-026 SHALL let reset override redirect, halt and any in-flight transaction; a response arriving after reset is treated as if in IDLE and ignored.

Configuration
REQ-027 SHALL, with INST_FETCH_MISALIGN_CHK_EN defined, set fetch_fault sticky on a redirect with redirect_pc[1:0]!=0 (fetch_pc still loaded), blocking requests until reset.
REQ-028 SHALL, without INST_FETCH_MISALIGN_CHK_EN, load fetch_pc <= {redirect_pc[31:2],2'b00} on redirect and tie fetch_fault to 0.

Verification
REQ-029 SHALL cover straight-line fetch: after reset, ready=1, response 1 cycle after each request with data 32'h0010_0093,... -> out_pc sequence 8000_0000, 8000_0004, 8000_0008 with matching out_inst.
REQ-030 SHALL cover back-pressure: out_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req_valid=0, no data lost; out_ready=1 -> in-order release.
REQ-031 SHALL cover redirect during WAIT: redirect_pc=32'h8000_0100 -> out_valid=0 next cycle, the stale response is dropped, next request addr=8000_0100.
REQ-032 SHALL cover redirect coincident with a response: the response is dropped, state returns to IDLE, next request addr=redirect_pc.
REQ-033 SHALL cover halt: halt=1 while in WAIT -> the pending response is enqueued, no further requests, the FIFO drains to empty.
REQ-034 SHALL cover misalignment: with the macro, redirect_pc=32'h8000_0102 -> fetch_fault=1 and no requests until reset; without the macro, next request addr=8000_0100.
